object_bounds_tracker: RTL and testbench
========================================

# object_bounds_tracker

Scans the thresholded camera pixel stream and, once per frame, produces the detected object's bounding box (x_min, x_max, y_min, y_max) and pixel centroid (x_cen, y_cen). These are exactly the coordinate inputs the superimpose/overlap stage consumes. The block sits between the colour-threshold stage and the overlap/coloriser path. Accumulation runs in real time. The centroid is computed after frame end with a sequential divider, and outputs update atomically once per frame.

## Interface
- COORD_W, 9, coordinate width (matches overlap coordinate inputs)
- H_ACTIVE, 320, active columns
- V_ACTIVE, 240, active rows
- MIN_PIXELS, 64, minimum matched-pixel count for a valid detection
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse before the first pixel of a frame
- frame_end  in  1  one-cycle pulse on or after the last pixel of a frame
- pixel_valid  in  1  pixel_column/pixel_row/pixel_match valid this cycle
- pixel_column  in  COORD_W  column of current pixel, 0..H_ACTIVE-1
- pixel_row  in  COORD_W  row of current pixel, 0..V_ACTIVE-1
- pixel_match  in  1  pixel passed colour threshold
- x_min, x_max, y_min, y_max  out  COORD_W each  bounds; min inclusive, max exclusive
- x_cen, y_cen  out  COORD_W each  floor of centroid
- detected  out  1  last published frame met MIN_PIXELS
- bounds_valid  out  1  one-cycle pulse when outputs update
- busy  out  1  centroid computation in progress
- overrun  out  1  sticky; a frame_end was dropped while busy

## Operation
- Accumulators: cnt (17 b), sum_x and sum_y (25 b), run_xmin/run_ymin (init all-ones), run_xmax/run_ymax (init 0).
- frame_start clears the accumulators. Any partial frame without a frame_end is discarded.
- Each cycle with pixel_valid && pixel_match: cnt++, sum_x += col, sum_y += row, and the running min/max update.
- A pixel on the same cycle as frame_start counts toward the new frame. A pixel on the same cycle as frame_end is included in the snapshot.
- On frame_end in IDLE: snapshot cnt, sums, min and max into operand registers. The accumulators stay free for the next frame.
- FSM states: IDLE, CHECK, DIV_X, DIV_Y, PUBLISH.
  - IDLE -> CHECK on frame_end.
  - CHECK -> PUBLISH if snap_cnt < MIN_PIXELS. This also guards divide-by-zero.
  - CHECK -> DIV_X otherwise.
  - DIV_X -> DIV_Y on divider done.
  - DIV_Y -> PUBLISH on divider done.
  - PUBLISH -> IDLE.
- PUBLISH with a valid detection: load all six outputs and set detected=1.
  - x_max = snap_xmax+1 and y_max = snap_ymax+1, so max 320/240 fits 9 b.
  - x_cen = floor(sum_x/cnt), y_cen = floor(sum_y/cnt), truncated to COORD_W.
- PUBLISH with an invalid detection: detected=0, and the six coordinates hold their previous values.
- bounds_valid pulses in PUBLISH in both cases.
- frame_end while busy: the frame is dropped and overrun is set. The result in flight is unaffected.
- busy = state != IDLE.

## Timing
- Reset values: all six coordinates 0, detected 0, bounds_valid 0, busy 0, overrun 0, FSM IDLE.
- All-zero bounds make overlap draw nothing.
- Reset mid-operation aborts immediately with no partial publish.
- Divider: restoring, 1 quotient bit per cycle, 25 iterations, plus 1 load cycle = 26 cycles per division.
- Latency from the edge sampling frame_end to the bounds_valid edge:
  - valid detection: 1 (CHECK) + 26 + 26 + 1 = 54 cycles.
  - under-threshold: 2 cycles.
- Outputs change only on the bounds_valid cycle, all six together.
- Worst-case busy time is 54 cycles, far below vertical blanking.

## Structure
- tracker_pkg: COORD_W, CNT_W=17, SUM_W=25, state enum, MIN_PIXELS default.
- Sub-module bounds_divider:
  - unsigned SUM_W/CNT_W restoring divider.
  - Ports: start, dividend, divisor, quotient, done.
  - Instantiated once and reused for x and y.
- The top level holds the accumulators, snapshot registers, FSM and output registers.

## Test plan
- 8x8 matched block at cols 100..107, rows 50..57 -> x_min=100, x_max=108, y_min=50, y_max=58, x_cen=103, y_cen=53, detected=1; bounds_valid exactly 54 cycles after frame_end.
- Whole frame matching -> 0/320/0/240, x_cen=159, y_cen=119, cnt=76800 with no overflow.
- 10 matched pixels after a valid frame -> detected=0, coordinates unchanged, bounds_valid 2 cycles after frame_end.
- Second frame_end 20 cycles after the first -> overrun=1; only the first frame publishes; next frame_start accepted normally.
- reset asserted during DIV_X -> all outputs 0 the same cycle, no bounds_valid; the following frame publishes correct values.
- frame_start twice without frame_end, blob only after the second -> result reflects only the second frame's blob.

Source files
------------

// File: rtl/object_bounds_tracker_pkg.sv
// Shared widths, FSM state encoding and defaults for the object bounds tracker.
package tracker_pkg;
  localparam int COORD_W        = 9;
  localparam int CNT_W          = 17;
  localparam int SUM_W          = 25;
  localparam int ITER_W         = 5;
  localparam logic [ITER_W-1:0] DIV_ITERS = ITER_W'(SUM_W);
  localparam int MIN_PIXELS_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV_X,
    ST_DIV_Y,
    ST_PUBLISH
  } state_t;
endpackage

// File: rtl/object_bounds_tracker_divider.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per cycle.
module bounds_divider
  import tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);
  logic [CNT_W-1:0]  rem;
  logic [SUM_W-1:0]  quo;
  logic [ITER_W-1:0] iter;
  logic [CNT_W:0]    trial;
  logic [CNT_W:0]    diff;

  // Trial subtraction; a set top bit of diff means the divisor did not fit
  always_comb begin
    trial = {rem, quo[SUM_W-1]};
    diff  = trial - {1'b0, divisor};
  end

  // Iteration counter and one-cycle done pulse after the last quotient bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter <= '0;
      done <= 1'b0;
    end else if (start) begin
      iter <= DIV_ITERS;
      done <= 1'b0;
    end else if (iter != '0) begin
      iter <= iter - 1'b1;
      done <= (iter == ITER_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  // Remainder/quotient shift register; dividend bits shift out as quotient bits shift in
  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
      quo <= dividend;
    end else if (iter != '0) begin
      if (!diff[CNT_W]) begin
        rem <= diff[CNT_W-1:0];
        quo <= {quo[SUM_W-2:0], 1'b1};
      end else begin
        rem <= trial[CNT_W-1:0];
        quo <= {quo[SUM_W-2:0], 1'b0};
      end
    end
  end

  assign quotient = quo;
endmodule

// File: rtl/object_bounds_tracker.sv
// Per-frame bounding box and centroid of thresholded pixels, published atomically.
module object_bounds_tracker #(
  parameter int COORD_W    = tracker_pkg::COORD_W,
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int MIN_PIXELS = tracker_pkg::MIN_PIXELS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] pixel_column,
  input  logic [COORD_W-1:0] pixel_row,
  input  logic               pixel_match,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] x_cen,
  output logic [COORD_W-1:0] y_cen,
  output logic               detected,
  output logic               bounds_valid,
  output logic               busy,
  output logic               overrun
);
  import tracker_pkg::*;

  // Exclusive upper bound from the last matched coordinate
  function automatic logic [COORD_W-1:0] bound_excl(input logic [COORD_W-1:0] v);
    return v + 1'b1;
  endfunction

  state_t state, state_nxt;

  logic [CNT_W-1:0]   acc_cnt, cnt_nxt, snap_cnt;
  logic [SUM_W-1:0]   acc_sx, sx_nxt, snap_sx;
  logic [SUM_W-1:0]   acc_sy, sy_nxt, snap_sy;
  logic [COORD_W-1:0] acc_xmin, xmin_nxt, snap_xmin;
  logic [COORD_W-1:0] acc_xmax, xmax_nxt, snap_xmax;
  logic [COORD_W-1:0] acc_ymin, ymin_nxt, snap_ymin;
  logic [COORD_W-1:0] acc_ymax, ymax_nxt, snap_ymax;
  logic [COORD_W-1:0] qx;
  logic               hit, under_min, accept_end;
  logic               div_start, div_done;
  logic [SUM_W-1:0]   div_dividend, div_quotient;
  logic               unused_q_hi;

  assign hit        = pixel_valid && pixel_match &&
                      (pixel_column < COORD_W'(H_ACTIVE)) && (pixel_row < COORD_W'(V_ACTIVE));
  assign under_min  = snap_cnt < CNT_W'(MIN_PIXELS);
  assign accept_end = frame_end && (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign unused_q_hi = ^div_quotient[SUM_W-1:COORD_W];

  // Next accumulator values: frame_start reinitialises, this cycle's pixel folds in
  always_comb begin
    if (frame_start) begin
      cnt_nxt  = '0;
      sx_nxt   = '0;
      sy_nxt   = '0;
      xmin_nxt = '1;
      xmax_nxt = '0;
      ymin_nxt = '1;
      ymax_nxt = '0;
    end else begin
      cnt_nxt  = acc_cnt;
      sx_nxt   = acc_sx;
      sy_nxt   = acc_sy;
      xmin_nxt = acc_xmin;
      xmax_nxt = acc_xmax;
      ymin_nxt = acc_ymin;
      ymax_nxt = acc_ymax;
    end
    if (hit) begin
      cnt_nxt  = cnt_nxt + 1'b1;
      sx_nxt   = sx_nxt + SUM_W'(pixel_column);
      sy_nxt   = sy_nxt + SUM_W'(pixel_row);
      xmin_nxt = (pixel_column < xmin_nxt) ? pixel_column : xmin_nxt;
      xmax_nxt = (pixel_column > xmax_nxt) ? pixel_column : xmax_nxt;
      ymin_nxt = (pixel_row < ymin_nxt) ? pixel_row : ymin_nxt;
      ymax_nxt = (pixel_row > ymax_nxt) ? pixel_row : ymax_nxt;
    end
  end

  // Running accumulators for the frame currently streaming in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt  <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
    end else begin
      acc_cnt  <= cnt_nxt;
      acc_sx   <= sx_nxt;
      acc_sy   <= sy_nxt;
      acc_xmin <= xmin_nxt;
      acc_xmax <= xmax_nxt;
      acc_ymin <= ymin_nxt;
      acc_ymax <= ymax_nxt;
    end
  end

  // Snapshot of the finished frame, including a pixel coincident with frame_end
  always_ff @(posedge clk) begin
    if (accept_end) begin
      snap_cnt  <= cnt_nxt;
      snap_sx   <= sx_nxt;
      snap_sy   <= sy_nxt;
      snap_xmin <= xmin_nxt;
      snap_xmax <= xmax_nxt;
      snap_ymin <= ymin_nxt;
      snap_ymax <= ymax_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and divider sequencing; y division launches on x done
  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_dividend = snap_sx;
    case (state)
      ST_IDLE:    if (frame_end) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (under_min) begin
          state_nxt = ST_PUBLISH;
        end else begin
          div_start = 1'b1;
          state_nxt = ST_DIV_X;
        end
      end
      ST_DIV_X: begin
        div_dividend = snap_sy;
        if (div_done) begin
          div_start = 1'b1;
          state_nxt = ST_DIV_Y;
        end
      end
      ST_DIV_Y:   if (div_done) state_nxt = ST_PUBLISH;
      ST_PUBLISH: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  bounds_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (snap_cnt),
    .quotient (div_quotient),
    .done     (div_done)
  );

  // Hold the x centroid while the divider is reused for y
  always_ff @(posedge clk) begin
    if (state == ST_DIV_X && div_done) qx <= div_quotient[COORD_W-1:0];
  end

  // Published outputs, bounds_valid pulse and sticky overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      x_cen        <= '0;
      y_cen        <= '0;
      detected     <= 1'b0;
      bounds_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      bounds_valid <= (state == ST_PUBLISH);
      if (frame_end && state != ST_IDLE) overrun <= 1'b1;
      if (state == ST_PUBLISH) begin
        detected <= !under_min;
        if (!under_min) begin
          x_min <= snap_xmin;
          x_max <= bound_excl(snap_xmax);
          y_min <= snap_ymin;
          y_max <= bound_excl(snap_ymax);
          x_cen <= qx;
          y_cen <= div_quotient[COORD_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_object_bounds_tracker.sv
// Directed bench for object_bounds_tracker with hand-computed expectations.
module tb_object_bounds_tracker;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [CW-1:0] pixel_column = '0;
  logic [CW-1:0] pixel_row = '0;
  logic          pixel_match = 1'b0;
  logic [CW-1:0] x_min, x_max, y_min, y_max, x_cen, y_cen;
  logic          detected, bounds_valid, busy, overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int lat, pulses, busy0;

  always #5 clk = ~clk;

  object_bounds_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .pixel_valid  (pixel_valid),
    .pixel_column (pixel_column),
    .pixel_row    (pixel_row),
    .pixel_match  (pixel_match),
    .x_min        (x_min),
    .x_max        (x_max),
    .y_min        (y_min),
    .y_max        (y_max),
    .x_cen        (x_cen),
    .y_cen        (y_cen),
    .detected     (detected),
    .bounds_valid (bounds_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_out(input string t, input int xmn, input int xmx, input int ymn,
                           input int ymx, input int xc, input int yc, input int det);
    check({t, ".x_min"}, 32'(x_min), xmn);
    check({t, ".x_max"}, 32'(x_max), xmx);
    check({t, ".y_min"}, 32'(y_min), ymn);
    check({t, ".y_max"}, 32'(y_max), ymx);
    check({t, ".x_cen"}, 32'(x_cen), xc);
    check({t, ".y_cen"}, 32'(y_cen), yc);
    check({t, ".detected"}, 32'(detected), det);
  endtask

  task automatic start_frame();
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Stream a matched w x h block; optionally raise frame_end with the last pixel
  task automatic send_block(input int c0, input int r0, input int w, input int h, input bit fe_last);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        @(negedge clk);
        pixel_valid  = 1'b1;
        pixel_match  = 1'b1;
        pixel_column = CW'(c0 + c);
        pixel_row    = CW'(r0 + r);
        if (fe_last && r == h - 1 && c == w - 1) frame_end = 1'b1;
      end
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_end   = 1'b1;
  endtask

  // Observe 120 cycles after the edge sampling frame_end; k counts edges since then
  task automatic run_wait(input int fe2_at, input int rst_at, output int lat_o,
                          output int pulses_o, output int busy_o);
    lat_o = -1;
    pulses_o = 0;
    busy_o = 0;
    @(negedge clk);
    for (int k = 0; k < 120; k++) begin
      if (k > 0) @(negedge clk);
      frame_end   = (k == fe2_at);
      pixel_valid = 1'b0;
      if (k == 0) busy_o = int'(busy);
      if (bounds_valid) begin
        pulses_o++;
        if (lat_o < 0) lat_o = k;
      end
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        check_out("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        check("rst_mid.busy", 32'(busy), 0);
        check("rst_mid.bounds_valid", 32'(bounds_valid), 0);
      end
      if (k == rst_at + 2) reset = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset.bounds_valid", 32'(bounds_valid), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.overrun", 32'(overrun), 0);

    // 8x8 blob, frame_end coincident with the last pixel
    start_frame();
    send_block(100, 50, 8, 8, 1'b1);
    run_wait(-1, -10, lat, pulses, busy0);
    check("blob.latency", lat, 54);
    check("blob.pulses", pulses, 1);
    check("blob.busy_after_end", busy0, 1);
    check("blob.busy_idle", 32'(busy), 0);
    check_out("blob", 100, 108, 50, 58, 103, 53, 1);

    // Under-threshold frame keeps coordinates
    start_frame();
    send_block(30, 30, 10, 1, 1'b0);
    end_frame();
    run_wait(-1, -10, lat, pulses, busy0);
    check("small.latency", lat, 2);
    check("small.pulses", pulses, 1);
    check_out("small", 100, 108, 50, 58, 103, 53, 0);

    // Second frame_end during division is dropped
    start_frame();
    send_block(10, 20, 8, 8, 1'b0);
    end_frame();
    run_wait(20, -10, lat, pulses, busy0);
    check("ovr.latency", lat, 54);
    check("ovr.pulses", pulses, 1);
    check("ovr.overrun", 32'(overrun), 1);
    check_out("ovr", 10, 18, 20, 28, 13, 23, 1);

    // Reset during DIV_X: no publish
    start_frame();
    send_block(200, 100, 8, 8, 1'b0);
    end_frame();
    run_wait(-1, 10, lat, pulses, busy0);
    check("rst.pulses", pulses, 0);
    check("rst.overrun", 32'(overrun), 0);

    // Double frame_start: only the second blob counts
    start_frame();
    send_block(200, 100, 8, 8, 1'b0);
    start_frame();
    send_block(40, 60, 8, 8, 1'b0);
    end_frame();
    run_wait(-1, -10, lat, pulses, busy0);
    check("dbl.latency", lat, 54);
    check("dbl.pulses", pulses, 1);
    check_out("dbl", 40, 48, 60, 68, 43, 63, 1);

    // Whole frame matching
    start_frame();
    send_block(0, 0, 320, 240, 1'b1);
    run_wait(-1, -10, lat, pulses, busy0);
    check("full.latency", lat, 54);
    check_out("full", 0, 320, 0, 240, 159, 119, 1);
    check("full.overrun", 32'(overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
